// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_pkg
//  Description : Shared types and constants for the PS/2 host transmit path
//                and its clock conditioning.
//  Revision    : 1.0 - initial release
// ============================================================================
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        INHIBIT  = 3'd1,
        RTS      = 3'd2,
        SEND     = 3'd3,
        ACK      = 3'd4,
        WAITIDLE = 3'd5
    } state_t;

    // Frame shape: 8 data bits, then parity, then stop on the 10th fall
    localparam int DATA_BITS = 8;
    localparam int STOP_FALL = 10;

    // Default timing at a 100 MHz system clock
    localparam int DEF_INHIBIT_CYCLES = 12000;
    localparam int DEF_RTS_CYCLES     = 200;
    localparam int DEF_TIMEOUT_CYCLES = 2000000;
    localparam int DEF_FILTER_LEN     = 8;

    // Largest of three values, used to size the shared phase/timeout counter
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_clk_filter.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_clk_filter
//  Description : Synchronizes the raw PS/2 clock, rejects glitches shorter
//                than FILTER_LEN samples and emits a 1-cycle fall pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_clk_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_ps2c,
    output logic o_clk_filt,
    output logic o_fall
);

    localparam int              CW     = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CW-1:0]   c_last = CW'(FILTER_LEN - 1);

    logic          r_meta;
    logic          r_sync;
    logic          r_filt;
    logic          r_fall;
    logic [CW-1:0] r_cnt;

    // Two-flop synchronizer; idles high like the released line
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_ps2c;
            r_sync <= r_meta;
        end
    end

    // Accept a new level only after FILTER_LEN consecutive disagreeing samples
    always_ff @(posedge clk) begin
        if (rst) begin
            r_filt <= 1'b1;
            r_cnt  <= '0;
            r_fall <= 1'b0;
        end else begin
            r_fall <= 1'b0;
            if (r_sync == r_filt) begin
                r_cnt <= '0;
            end else if (r_cnt == c_last) begin
                r_filt <= r_sync;
                r_cnt  <= '0;
                r_fall <= r_filt;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_clk_filt = r_filt;
    assign o_fall     = r_fall;

endmodule
`default_nettype wire

// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_host_tx
//  Description : PS/2 host-to-device transmitter. Inhibits the bus, issues a
//                request-to-send, shifts one byte plus odd parity out on the
//                device-generated clock and reports DONE, NACK or TOUT.
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
    parameter int RTS_CYCLES     = DEF_RTS_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int FILTER_LEN     = DEF_FILTER_LEN
) (
    input  logic       C,
    input  logic       R,
    input  logic       START,
    input  logic [7:0] DIN,
    input  logic       PS2C_I,
    input  logic       PS2D_I,
    output logic       PS2C_OE,
    output logic       PS2D_OE,
    output logic       BUSY,
    output logic       DONE,
    output logic       NACK,
    output logic       TOUT
);

    localparam int            CW          = $clog2(max3(INHIBIT_CYCLES, RTS_CYCLES, TIMEOUT_CYCLES)) + 1;
    localparam logic [CW-1:0] c_inh_last  = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] c_rts_last  = CW'(RTS_CYCLES - 1);
    localparam logic [CW-1:0] c_tout_last = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]    c_last_data = 4'(DATA_BITS);
    localparam logic [3:0]    c_par_fall  = 4'(DATA_BITS + 1);
    localparam logic [3:0]    c_stop_fall = 4'(STOP_FALL);

    state_t        r_state, w_state;
    logic [7:0]    r_data,  w_data;
    logic          r_par,   w_par;
    logic [3:0]    r_bit,   w_bit;
    logic [CW-1:0] r_cnt,   w_cnt;
    logic          r_c_oe,  w_c_oe;
    logic          r_d_oe,  w_d_oe;
    logic          r_busy,  w_busy;
    logic          r_done,  w_done;
    logic          r_nack,  w_nack;
    logic          r_tout,  w_tout;
    logic [3:0]    w_fallno;
    logic          w_clk_filt;
    logic          w_fall;
    logic          r_d_meta, r_d_sync;

    ps2_clk_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_clk_filter (
        .clk        (C),
        .rst        (R),
        .i_ps2c     (PS2C_I),
        .o_clk_filt (w_clk_filt),
        .o_fall     (w_fall)
    );

    // Two-flop synchronizer for the data line (used for ACK and idle detect)
    always_ff @(posedge C) begin
        if (R) begin
            r_d_meta <= 1'b1;
            r_d_sync <= 1'b1;
        end else begin
            r_d_meta <= PS2D_I;
            r_d_sync <= r_d_meta;
        end
    end

    // State and datapath registers; all line drives and pulses are registered
    always_ff @(posedge C) begin
        if (R) begin
            r_state <= IDLE;
            r_data  <= '0;
            r_par   <= 1'b0;
            r_bit   <= '0;
            r_cnt   <= '0;
            r_c_oe  <= 1'b0;
            r_d_oe  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_nack  <= 1'b0;
            r_tout  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_data  <= w_data;
            r_par   <= w_par;
            r_bit   <= w_bit;
            r_cnt   <= w_cnt;
            r_c_oe  <= w_c_oe;
            r_d_oe  <= w_d_oe;
            r_busy  <= w_busy;
            r_done  <= w_done;
            r_nack  <= w_nack;
            r_tout  <= w_tout;
        end
    end

    // Next-state logic; one counter serves inhibit, RTS and timeout phases
    always_comb begin
        w_state  = r_state;
        w_data   = r_data;
        w_par    = r_par;
        w_bit    = r_bit;
        w_cnt    = r_cnt;
        w_c_oe   = r_c_oe;
        w_d_oe   = r_d_oe;
        w_busy   = r_busy;
        w_done   = 1'b0;
        w_nack   = 1'b0;
        w_tout   = 1'b0;
        w_fallno = r_bit + 4'd1;

        case (r_state)
            IDLE: begin
                w_c_oe = 1'b0;
                w_d_oe = 1'b0;
                w_busy = 1'b0;
                if (START) begin
                    w_data  = DIN;
                    w_par   = ~^DIN;
                    w_bit   = '0;
                    w_cnt   = '0;
                    w_c_oe  = 1'b1;
                    w_busy  = 1'b1;
                    w_state = INHIBIT;
                end
            end

            INHIBIT: begin
                if (r_cnt == c_inh_last) begin
                    w_cnt   = '0;
                    w_d_oe  = 1'b1;   // start bit
                    w_state = RTS;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end

            RTS: begin
                if (r_cnt == c_rts_last) begin
                    w_cnt   = '0;
                    w_c_oe  = 1'b0;   // hand the clock to the device
                    w_state = SEND;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end

            SEND, ACK, WAITIDLE: begin
                if (r_cnt == c_tout_last) begin
                    // Timeout wins over a coincident fall
                    w_tout  = 1'b1;
                    w_busy  = 1'b0;
                    w_c_oe  = 1'b0;
                    w_d_oe  = 1'b0;
                    w_cnt   = '0;
                    w_state = IDLE;
                end else begin
                    w_cnt = w_fall ? '0 : r_cnt + 1'b1;
                    case (r_state)
                        SEND: begin
                            if (w_fall) begin
                                w_bit = w_fallno;
                                if (w_fallno <= c_last_data) begin
                                    w_d_oe = ~r_data[r_bit[2:0]];
                                end else if (w_fallno == c_par_fall) begin
                                    w_d_oe = ~r_par;
                                end else if (w_fallno == c_stop_fall) begin
                                    w_d_oe  = 1'b0;
                                    w_state = ACK;
                                end
                            end
                        end
                        ACK: begin
                            if (w_fall) begin
                                if (!r_d_sync) begin
                                    w_state = WAITIDLE;
                                end else begin
                                    w_nack  = 1'b1;
                                    w_busy  = 1'b0;
                                    w_state = IDLE;
                                end
                            end
                        end
                        WAITIDLE: begin
                            if (w_clk_filt && r_d_sync) begin
                                w_done  = 1'b1;
                                w_busy  = 1'b0;
                                w_state = IDLE;
                            end
                        end
                        default: ;
                    endcase
                end
            end

            default: begin
                w_state = IDLE;
            end
        endcase
    end

    assign PS2C_OE = r_c_oe;
    assign PS2D_OE = r_d_oe;
    assign BUSY    = r_busy;
    assign DONE    = r_done;
    assign NACK    = r_nack;
    assign TOUT    = r_tout;

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ps2_host_tx
//  Description : Testbench for ps2_host_tx with a behavioural PS/2 device and
//                a scoreboard of expected completion events.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_host_tx;

    localparam int INH = 100;
    localparam int RTS = 20;
    localparam int TMO = 2000;
    localparam int FLT = 8;
    localparam int H   = 40;     // device clock half period in system cycles

    localparam logic [1:0] K_DONE = 2'd1;
    localparam logic [1:0] K_NACK = 2'd2;
    localparam logic [1:0] K_TOUT = 2'd3;

    typedef struct packed {
        logic [1:0]  kind;
        logic [10:0] frame;   // {stop, parity, data[7:0], start} as seen by the device
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  din;
    logic        dev_clk_low;
    logic        dev_dat_low;
    logic        glitch;
    logic        w_c_oe, w_d_oe, w_busy, w_done, w_nack, w_tout;
    logic        w_ps2c_line, w_ps2d_line, w_ps2c_in;
    logic [10:0] dev_rx;
    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    // Open-drain bus: either side pulling low wins
    assign w_ps2c_line = ~(w_c_oe | dev_clk_low);
    assign w_ps2d_line = ~(w_d_oe | dev_dat_low);
    assign w_ps2c_in   = w_ps2c_line & ~glitch;

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .RTS_CYCLES     (RTS),
        .TIMEOUT_CYCLES (TMO),
        .FILTER_LEN     (FLT)
    ) dut (
        .C       (clk),
        .R       (rst),
        .START   (start),
        .DIN     (din),
        .PS2C_I  (w_ps2c_in),
        .PS2D_I  (w_ps2d_line),
        .PS2C_OE (w_c_oe),
        .PS2D_OE (w_d_oe),
        .BUSY    (w_busy),
        .DONE    (w_done),
        .NACK    (w_nack),
        .TOUT    (w_tout)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [1:0] kind, input logic [10:0] frame);
        exp_t e;
        e.kind  = kind;
        e.frame = frame;
        return e;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Wait for the host to grab the clock and then release it after RTS
    task automatic wait_release(output bit ok);
        int n;
        n = 0;
        while (!w_c_oe && n < 50) begin tick(1); n++; end
        ok = w_c_oe;
        n = 0;
        while (w_c_oe && n < INH + RTS + 50) begin tick(1); n++; end
        ok = ok && !w_c_oe;
        check("clock_release", ok, 1);
    endtask

    // Behavioural device: samples data on each rising clock, then ACKs
    task automatic dev_xfer(input int nclk, input bit do_ack, input bit ack_low, input int gk);
        bit ok;
        wait_release(ok);
        if (!ok) return;
        tick(H);
        dev_rx    = '0;
        dev_rx[0] = w_ps2d_line;
        for (int k = 1; k <= nclk; k++) begin
            dev_clk_low = 1'b1;
            tick(H);
            dev_clk_low = 1'b0;
            dev_rx[k]   = w_ps2d_line;
            check("busy_during", w_busy, 1);
            if (k == gk) begin
                tick(10);
                glitch = 1'b1;
                tick(3);
                glitch = 1'b0;
                tick(H - 13);
            end else begin
                tick(H);
            end
        end
        if (do_ack) begin
            dev_dat_low = ack_low;
            tick(5);
            dev_clk_low = 1'b1;
            tick(H);
            dev_clk_low = 1'b0;
            tick(H / 2);
            dev_dat_low = 1'b0;
        end
    endtask

    task automatic wait_idle;
        int n;
        n = 0;
        while (w_busy && n < 4 * H) begin tick(1); n++; end
        check("busy_drop", w_busy, 0);
        tick(H);
    endtask

    task automatic issue(input logic [7:0] d);
        start = 1'b1;
        din   = d;
        tick(1);
        start = 1'b0;
        din   = 8'h00;
        check("busy_after_start", w_busy, 1);
    endtask

    // Monitor: every completion pulse is matched against the scoreboard
    always @(negedge clk) begin
        if (w_done | w_nack | w_tout) begin
            exp_t       e;
            logic [1:0] k;
            k = w_done ? K_DONE : (w_nack ? K_NACK : K_TOUT);
            check("pulse_onehot", $countones({w_done, w_nack, w_tout}), 1);
            check("busy_at_pulse", w_busy, 0);
            check("lines_at_pulse", {w_c_oe, w_d_oe}, 0);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: got kind %0d expected none", k);
            end else begin
                e = sb.pop_front();
                check("pulse_kind", k, e.kind);
                if (k == K_DONE) check("device_frame", dev_rx, e.frame);
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got no finish expected finish within time limit");
        $fatal(1);
    end

    initial begin
        int n;
        bit ok;
        rst = 1'b1; start = 1'b0; din = 8'h00;
        dev_clk_low = 1'b0; dev_dat_low = 1'b0; glitch = 1'b0;
        tick(3);
        check("reset_outputs", {w_c_oe, w_d_oe, w_busy, w_done, w_nack, w_tout}, 0);
        rst = 1'b0;
        tick(2);
        check("idle_outputs", {w_c_oe, w_d_oe, w_busy, w_done, w_nack, w_tout}, 0);

        // 0xED: parity 1; a second START during INHIBIT must be ignored
        sb.push_back(mk(K_DONE, 11'b1_1_11101101_0));
        issue(8'hED);
        tick(5);
        start = 1'b1; din = 8'h00; tick(1); start = 1'b0;
        check("inhibit_lines", {w_c_oe, w_d_oe}, 2'b10);
        dev_xfer(10, 1'b1, 1'b1, 0);
        wait_idle();

        // 0xF4: parity 0
        sb.push_back(mk(K_DONE, 11'b1_0_11110100_0));
        issue(8'hF4);
        dev_xfer(10, 1'b1, 1'b1, 0);
        wait_idle();

        // 0x00 with the device leaving data high at ACK
        sb.push_back(mk(K_NACK, 11'b0));
        issue(8'h00);
        dev_xfer(10, 1'b1, 1'b0, 0);
        wait_idle();
        check("nack_lines", {w_c_oe, w_d_oe}, 0);

        // Device never clocks: TOUT exactly TMO cycles after release
        sb.push_back(mk(K_TOUT, 11'b0));
        issue(8'h5A);
        wait_release(ok);
        n = 0;
        while (!w_tout && n < TMO + 100) begin tick(1); n++; end
        check("tout_latency", n, TMO);
        tick(2);
        check("tout_released", {w_c_oe, w_d_oe, w_busy}, 0);

        // Reset after fall #5, then a clean 0xED
        issue(8'hED);
        dev_xfer(5, 1'b0, 1'b0, 0);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("reset_mid", {w_c_oe, w_d_oe, w_busy}, 0);
        tick(H);
        sb.push_back(mk(K_DONE, 11'b1_1_11101101_0));
        issue(8'hED);
        dev_xfer(10, 1'b1, 1'b1, 0);
        wait_idle();

        // 3-cycle clock glitch during SEND: 0xA5, parity 1
        sb.push_back(mk(K_DONE, 11'b1_1_10100101_0));
        issue(8'hA5);
        dev_xfer(10, 1'b1, 1'b1, 3);
        wait_idle();

        tick(20);
        check("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
